// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: fetch FSM states, the canonical NOP word and
// the branch funct3 encodings that the fetch stage and control_unit agree on.
package riscv_pkg;

    localparam int          XLEN      = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;
    localparam logic [2:0] F3_BLT = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_FETCH = 2'b01,
        ST_EXEC  = 2'b10,
        ST_ERROR = 2'b11
    } fetch_state_e;

    // Instruction addresses must be word aligned.
    function automatic logic is_misaligned(input logic [1:0] addr_lsb);
        return (addr_lsb != 2'b00);
    endfunction

endpackage

// File: rtl/pc_next_calc.sv
// Combinational next-PC selection: sequential (pc+4) or branch (pc+imm_ext),
// with word-alignment check on the selected target. All sums wrap modulo 2^XLEN.
module pc_next_calc
    import riscv_pkg::*;
#(
    parameter int XLEN = riscv_pkg::XLEN
) (
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] imm_ext,
    input  logic            pc_src,
    output logic [XLEN-1:0] next_pc,
    output logic [XLEN-1:0] pc_plus4,
    output logic            misaligned
);

    logic [XLEN-1:0] pc_branch_s;

    assign pc_plus4    = pc + XLEN'(4);
    assign pc_branch_s = pc + imm_ext;

    // Select the commit target and flag a non-word-aligned result.
    always_comb begin
        next_pc    = pc_plus4;
        misaligned = 1'b0;
        if (pc_src) begin
            next_pc = pc_branch_s;
        end else begin
            next_pc = pc_plus4;
        end
        misaligned = is_misaligned(next_pc[1:0]);
    end

endmodule

// File: rtl/fetch_pc_unit.sv
// Instruction-fetch stage: owns the PC, fetches over a req/ready handshake and
// advances on commit. Optional retired-instruction counter under FETCH_INSTRET_EN.
module fetch_pc_unit #(
    parameter int               XLEN      = riscv_pkg::XLEN,
    parameter logic [XLEN-1:0]  RESET_PC  = {XLEN{1'b0}},
    parameter logic [31:0]      NOP_INSTR = riscv_pkg::NOP_INSTR
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            pc_src,
    input  logic [XLEN-1:0] imm_ext,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic [31:0]     imem_rdata,
    output logic [31:0]     instr,
    output logic            instr_valid,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    output logic            misalign_err,
    output logic [31:0]     instret
);
    import riscv_pkg::*;

    fetch_state_e    state_r;
    fetch_state_e    next_state_s;
    logic [XLEN-1:0] pc_r;
    logic [31:0]     instr_r;
    logic            valid_r;
    logic            err_r;
    logic            req_r;
    logic [XLEN-1:0] next_pc_s;
    logic            misaligned_s;
    logic            commit_s;

    pc_next_calc #(.XLEN(XLEN)) u_pc_next_calc (
        .pc         (pc_r),
        .imm_ext    (imm_ext),
        .pc_src     (pc_src),
        .next_pc    (next_pc_s),
        .pc_plus4   (pc_plus4),
        .misaligned (misaligned_s)
    );

    assign commit_s = (state_r == ST_EXEC) && !stall;

    // Next-state decode for the fetch FSM.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE:  next_state_s = ST_FETCH;
            ST_FETCH: begin
                if (imem_ready) begin
                    next_state_s = ST_EXEC;
                end else begin
                    next_state_s = ST_FETCH;
                end
            end
            ST_EXEC: begin
                if (stall) begin
                    next_state_s = ST_EXEC;
                end else if (misaligned_s) begin
                    next_state_s = ST_ERROR;
                end else begin
                    next_state_s = ST_FETCH;
                end
            end
            ST_ERROR: next_state_s = ST_ERROR;
            default:  next_state_s = ST_IDLE;
        endcase
    end

    // State, PC, held instruction and status registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            pc_r    <= RESET_PC;
            instr_r <= NOP_INSTR;
            valid_r <= 1'b0;
            err_r   <= 1'b0;
            req_r   <= 1'b0;
        end else begin
            state_r <= next_state_s;
            // imem_req is registered from the next state so it is glitch-free.
            req_r   <= (next_state_s == ST_FETCH);
            case (state_r)
                ST_FETCH: begin
                    if (imem_ready) begin
                        instr_r <= imem_rdata;
                        valid_r <= 1'b1;
                    end
                end
                ST_EXEC: begin
                    if (!stall) begin
                        instr_r <= NOP_INSTR;
                        valid_r <= 1'b0;
                        if (misaligned_s) begin
                            err_r <= 1'b1;
                        end else begin
                            pc_r <= next_pc_s;
                        end
                    end
                end
                default: begin
                    valid_r <= 1'b0;
                end
            endcase
        end
    end

`ifdef FETCH_INSTRET_EN
    logic [31:0] instret_r;

    // Count commits that proceed to the next fetch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instret_r <= 32'd0;
        end else if (commit_s && !misaligned_s) begin
            instret_r <= instret_r + 32'd1;
        end
    end

    assign instret = instret_r;
`else
    assign instret = 32'd0;
`endif

    assign imem_req     = req_r;
    assign imem_addr    = pc_r;
    assign pc           = pc_r;
    assign instr        = instr_r;
    assign instr_valid  = valid_r;
    assign misalign_err = err_r;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit: sequential fetch, branch, wait states,
// stall, misalignment trap and asynchronous reset.
module tb_fetch_pc_unit;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        pc_src;
    logic [31:0] imm_ext;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        misalign_err;
    logic [31:0] instret;

    int n_checks;
    int n_errors;
    int n_retired;

`ifdef FETCH_INSTRET_EN
    localparam bit INSTRET_ON = 1'b1;
`else
    localparam bit INSTRET_ON = 1'b0;
`endif

    localparam logic [31:0] NOP = 32'h0000_0013;

    fetch_pc_unit dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .pc_src       (pc_src),
        .imm_ext      (imm_ext),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ready   (imem_ready),
        .imem_rdata   (imem_rdata),
        .instr        (instr),
        .instr_valid  (instr_valid),
        .pc           (pc),
        .pc_plus4     (pc_plus4),
        .misalign_err (misalign_err),
        .instret      (instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [31:0] exp_instret(input int n);
        return INSTRET_ON ? 32'(n) : 32'd0;
    endfunction

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_pc"},    pc, 32'h0000_0000);
        chk({tag, "_instr"}, instr, NOP);
        chk({tag, "_valid"}, {31'd0, instr_valid}, 32'd0);
        chk({tag, "_req"},   {31'd0, imem_req}, 32'd0);
        chk({tag, "_err"},   {31'd0, misalign_err}, 32'd0);
        chk({tag, "_instret"}, instret, 32'd0);
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        n_retired  = 0;
        rst        = 1'b1;
        stall      = 1'b0;
        pc_src     = 1'b0;
        imm_ext    = 32'd0;
        imem_ready = 1'b0;
        imem_rdata = 32'd0;

        // Reset state
        @(negedge clk);
        chk_reset_outputs("rst0");
        chk("rst0_pc_plus4", pc_plus4, 32'h0000_0004);

        // Sequential fetch with ready always high
        rst        = 1'b0;
        imem_ready = 1'b1;
        imem_rdata = 32'h00A0_0093;
        chk("idle_req", {31'd0, imem_req}, 32'd0);
        tick();
        chk("f0_req", {31'd0, imem_req}, 32'd1);
        chk("f0_addr", imem_addr, 32'h0000_0000);
        chk("f0_valid", {31'd0, instr_valid}, 32'd0);
        tick();
        chk("e0_valid", {31'd0, instr_valid}, 32'd1);
        chk("e0_instr", instr, 32'h00A0_0093);
        chk("e0_req", {31'd0, imem_req}, 32'd0);
        chk("e0_pc_plus4", pc_plus4, 32'h0000_0004);
        tick();
        n_retired = 1;
        chk("f4_addr", imem_addr, 32'h0000_0004);
        chk("f4_valid", {31'd0, instr_valid}, 32'd0);
        chk("f4_instr", instr, NOP);
        tick();
        chk("e4_valid", {31'd0, instr_valid}, 32'd1);
        tick();
        n_retired = 2;
        chk("f8_addr", imem_addr, 32'h0000_0008);
        chk("f8_instret", instret, exp_instret(n_retired));
        tick();
        tick();
        tick();
        tick();
        n_retired = 4;
        chk("f10_addr", imem_addr, 32'h0000_0010);

        // Backward branch from 0x10 by -8
        tick();
        chk("e10_pc", pc, 32'h0000_0010);
        pc_src  = 1'b1;
        imm_ext = 32'hFFFF_FFF8;
        tick();
        n_retired = 5;
        chk("br_addr", imem_addr, 32'h0000_0008);
        chk("br_instret", instret, exp_instret(n_retired));

        // Walk sequentially from 0x08 up to 0x20
        pc_src  = 1'b0;
        imm_ext = 32'd0;
        for (int k = 0; k < 6; k++) begin
            tick();
            tick();
        end
        n_retired = 11;
        chk("f20_addr", imem_addr, 32'h0000_0020);

        // Three wait-state cycles at 0x20; rdata ignored while not ready
        imem_ready = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
        for (int k = 0; k < 3; k++) begin
            chk("ws_req", {31'd0, imem_req}, 32'd1);
            chk("ws_addr", imem_addr, 32'h0000_0020);
            chk("ws_valid", {31'd0, instr_valid}, 32'd0);
            chk("ws_instr", instr, NOP);
            if (k < 2) tick();
        end
        imem_ready = 1'b1;
        imem_rdata = 32'h0041_8233;
        stall      = 1'b1;
        pc_src     = 1'b1;
        imm_ext    = 32'h0000_0100;
        tick();
        chk("ws_latch_instr", instr, 32'h0041_8233);
        chk("ws_latch_valid", {31'd0, instr_valid}, 32'd1);

        // Stall two cycles with pc_src toggling and rdata changing
        imem_rdata = 32'h1234_5678;
        pc_src     = 1'b0;
        tick();
        chk("st1_pc", pc, 32'h0000_0020);
        chk("st1_instr", instr, 32'h0041_8233);
        chk("st1_valid", {31'd0, instr_valid}, 32'd1);
        pc_src = 1'b1;
        tick();
        chk("st2_pc", pc, 32'h0000_0020);
        chk("st2_instr", instr, 32'h0041_8233);
        chk("st2_req", {31'd0, imem_req}, 32'd0);
        chk("st2_instret", instret, exp_instret(n_retired));
        stall  = 1'b0;
        pc_src = 1'b0;
        tick();
        n_retired = 12;
        chk("st_commit_addr", imem_addr, 32'h0000_0024);

        // Walk to 0x40 then take a misaligned branch
        for (int k = 0; k < 7; k++) begin
            tick();
            tick();
        end
        n_retired = 19;
        chk("f40_addr", imem_addr, 32'h0000_0040);
        tick();
        pc_src  = 1'b1;
        imm_ext = 32'h0000_0006;
        tick();
        chk("mis_err", {31'd0, misalign_err}, 32'd1);
        chk("mis_pc", pc, 32'h0000_0040);
        chk("mis_req", {31'd0, imem_req}, 32'd0);
        chk("mis_valid", {31'd0, instr_valid}, 32'd0);
        chk("mis_instr", instr, NOP);
        chk("mis_instret", instret, exp_instret(n_retired));
        pc_src = 1'b0;
        tick();
        tick();
        chk("err_hold_req", {31'd0, imem_req}, 32'd0);
        chk("err_hold_err", {31'd0, misalign_err}, 32'd1);
        chk("err_hold_pc", pc, 32'h0000_0040);

        // Reset out of ERROR
        rst = 1'b1;
        #1;
        chk_reset_outputs("rst_err");
        @(negedge clk);
        rst = 1'b0;
        tick();
        chk("post_err_addr", imem_addr, 32'h0000_0000);
        chk("post_err_req", {31'd0, imem_req}, 32'd1);

        // Move to FETCH at 0x4, then reset asynchronously mid-cycle
        imem_rdata = 32'h0000_0063;
        tick();
        tick();
        chk("af_addr", imem_addr, 32'h0000_0004);
        imem_ready = 1'b0;
        @(posedge clk);
        #2;
        imem_ready = 1'b1;
        rst        = 1'b1;
        #1;
        chk_reset_outputs("async");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rec_idle_req", {31'd0, imem_req}, 32'd0);
        imem_rdata = 32'h00C0_006F;
        tick();
        chk("rec_req", {31'd0, imem_req}, 32'd1);
        chk("rec_addr", imem_addr, 32'h0000_0000);
        tick();
        chk("rec_instr", instr, 32'h00C0_006F);
        chk("rec_valid", {31'd0, instr_valid}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
